// File: rtl/ram512_stream_loader.sv
// Streams words into a ram512 (LOAD) or back out of it (DUMP) over valid/ready handshakes.
// Optional running checksum is compiled in when CHECKSUM_EN is defined.
module ram512_stream_loader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 512
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start_load,
   input  logic              i_start_dump,
   input  logic [ADDR_W-1:0] i_base_addr,
   input  logic [ADDR_W:0]   i_length,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_out_valid,
   output logic [DATA_W-1:0] o_out_data,
   input  logic              i_out_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic [DATA_W-1:0] o_checksum,
   output logic [ADDR_W-1:0] o_ram_address,
   output logic [DATA_W-1:0] o_ram_data_in,
   output logic              o_ram_write_enable,
   input  logic [DATA_W-1:0] i_ram_data_out
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_LOAD, ST_RD_ISSUE, ST_RD_WAIT, ST_RD_OUT, ST_FIN
   } state_t;

   localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

   state_t              r_state, w_nextState;
   logic [ADDR_W-1:0]   r_ptr, r_addrHold;
   logic [ADDR_W:0]     r_remaining, w_lenClamped;
   logic [DATA_W-1:0]   r_outData;
   logic                w_loadHs, w_outHs, w_lastWord, w_driveAddr, w_start;

   assign w_lenClamped = (i_length > LP_DEPTH) ? LP_DEPTH : i_length;
   assign w_lastWord   = (r_remaining == {{ADDR_W{1'b0}}, 1'b1});
   assign w_start      = (r_state == ST_IDLE) && (i_start_load || i_start_dump);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      w_loadHs    = 1'b0;
      w_outHs     = 1'b0;
      w_driveAddr = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_start_load)
               w_nextState = (w_lenClamped == '0) ? ST_FIN : ST_LOAD;
            else if (i_start_dump)
               w_nextState = (w_lenClamped == '0) ? ST_FIN : ST_RD_ISSUE;
         end
         ST_LOAD: begin
            w_loadHs    = i_in_valid;
            w_driveAddr = i_in_valid;
            if (i_in_valid && w_lastWord) w_nextState = ST_FIN;
         end
         ST_RD_ISSUE: begin
            w_driveAddr = 1'b1;
            w_nextState = ST_RD_WAIT;
         end
         ST_RD_WAIT: w_nextState = ST_RD_OUT;
         ST_RD_OUT: begin
            w_outHs = i_out_ready;
            if (i_out_ready) w_nextState = w_lastWord ? ST_FIN : ST_RD_ISSUE;
         end
         ST_FIN:  w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // The RAM address holds its last driven value whenever no access is in progress.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_ptr       <= '0;
         r_remaining <= '0;
         r_addrHold  <= '0;
         r_outData   <= '0;
      end else begin
         if (w_driveAddr) r_addrHold <= r_ptr;
         if (w_start) begin
            r_ptr       <= i_base_addr;
            r_remaining <= w_lenClamped;
         end else if (w_loadHs || w_outHs) begin
            r_ptr       <= r_ptr + 1'b1;
            r_remaining <= r_remaining - 1'b1;
         end
         if (r_state == ST_RD_WAIT) r_outData <= i_ram_data_out;
      end
   end

   assign o_in_ready         = (r_state == ST_LOAD);
   assign o_out_valid        = (r_state == ST_RD_OUT);
   assign o_out_data         = r_outData;
   assign o_busy             = (r_state != ST_IDLE);
   assign o_done             = (r_state == ST_FIN);
   assign o_ram_address      = w_driveAddr ? r_ptr : r_addrHold;
   assign o_ram_data_in      = w_loadHs ? i_in_data : '0;
   assign o_ram_write_enable = w_loadHs;

`ifdef CHECKSUM_EN
   logic [DATA_W-1:0] r_checksum;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)      r_checksum <= '0;
      else if (w_start)  r_checksum <= '0;
      else if (w_loadHs) r_checksum <= r_checksum + i_in_data;
      else if (w_outHs)  r_checksum <= r_checksum + r_outData;
   end

   assign o_checksum = r_checksum;
`else
   assign o_checksum = '0;
`endif

endmodule

// File: tb/tb_ram512_stream_loader.sv
// Self-checking bench for ram512_stream_loader: behavioural ram512 plus an array/queue reference model.
// Expected checksums follow CHECKSUM_EN the same way the design does.
module tb_ram512_stream_loader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_start_load, i_start_dump;
   logic [8:0]  i_base_addr;
   logic [9:0]  i_length;
   logic        i_in_valid;
   logic [15:0] i_in_data;
   logic        o_in_ready, o_out_valid;
   logic [15:0] o_out_data;
   logic        i_out_ready;
   logic        o_busy, o_done;
   logic [15:0] o_checksum;
   logic [8:0]  o_ram_address;
   logic [15:0] o_ram_data_in;
   logic        o_ram_write_enable;
   logic [15:0] ramDataOut;

   int checks = 0;
   int failures = 0;

   logic [15:0] ramMem [512];
   logic [15:0] refMem [512];
   logic [15:0] stimWords [$];
   logic [8:0]  wrAddrQ [$];
   logic [15:0] wrDataQ [$];
   logic [15:0] outQ [$];
   int          doneCount = 0;
   int          outValidSeen = 0;
   int          stableViol = 0;
   logic        prevStall = 1'b0;
   logic [15:0] prevData = '0;

   ram512_stream_loader dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .i_start_load(i_start_load), .i_start_dump(i_start_dump),
      .i_base_addr(i_base_addr), .i_length(i_length),
      .i_in_valid(i_in_valid), .i_in_data(i_in_data), .o_in_ready(o_in_ready),
      .o_out_valid(o_out_valid), .o_out_data(o_out_data), .i_out_ready(i_out_ready),
      .o_busy(o_busy), .o_done(o_done), .o_checksum(o_checksum),
      .o_ram_address(o_ram_address), .o_ram_data_in(o_ram_data_in),
      .o_ram_write_enable(o_ram_write_enable), .i_ram_data_out(ramDataOut)
   );

   always #5 clk = ~clk;

   // ram512 behaviour: synchronous write, registered read one cycle after the address
   always @(posedge clk) begin
      if (o_ram_write_enable) ramMem[o_ram_address] <= o_ram_data_in;
      ramDataOut <= ramMem[o_ram_address];
   end

   // Passive observer on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         if (o_ram_write_enable) begin
            wrAddrQ.push_back(o_ram_address);
            wrDataQ.push_back(o_ram_data_in);
         end
         if (o_out_valid && i_out_ready) outQ.push_back(o_out_data);
         if (o_done) doneCount++;
         if (o_out_valid) outValidSeen++;
         if (prevStall && o_out_valid && (o_out_data !== prevData)) stableViol++;
         prevStall = o_out_valid && !i_out_ready;
         prevData  = o_out_data;
      end else begin
         prevStall = 1'b0;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic waitIdle(input int bound);
      int c = 0;
      while (o_busy && c < bound) begin
         @(posedge clk); #1;
         c++;
      end
      checkOutput("idleWithinBound", 32'(o_busy), 32'd0);
   endtask

   function automatic logic [15:0] expChecksum(input logic [15:0] sum);
`ifdef CHECKSUM_EN
      return sum;
`else
      return 16'h0000;
`endif
   endfunction

   // Drives one LOAD of stimWords, then compares the RAM write log and done/checksum against the model
   task automatic applyStimulus(input int base, input int len, input int gapPct, input bit alsoDump);
      int n, idx, cyc, startWr, startDone;
      bit hs;
      logic [15:0] sum = '0;
      n = (len > 512) ? 512 : len;
      startWr = wrAddrQ.size();
      startDone = doneCount;
      i_base_addr = 9'(base);
      i_length = 10'(len);
      i_start_load = 1'b1;
      i_start_dump = alsoDump;
      @(posedge clk); #1;
      i_start_load = 1'b0;
      i_start_dump = 1'b0;
      if (alsoDump) checkOutput("bothStartsLoadWins", 32'(o_in_ready), 32'd1);
      idx = 0;
      cyc = 0;
      while (idx < n && cyc < 20 * n + 50) begin
         i_in_valid = ($urandom_range(0, 99) >= 32'(gapPct));
         i_in_data = i_in_valid ? stimWords[idx] : 16'($urandom);
         hs = i_in_valid && o_in_ready;
         @(posedge clk); #1;
         if (hs) idx++;
         cyc++;
      end
      i_in_valid = 1'b0;
      checkOutput("loadAllAccepted", 32'(idx), 32'(n));
      waitIdle(10);
      for (int k = 0; k < n; k++) begin
         refMem[(base + k) % 512] = stimWords[k];
         sum += stimWords[k];
      end
      checkOutput("loadWriteCount", 32'(wrAddrQ.size() - startWr), 32'(n));
      if (wrAddrQ.size() - startWr == n) begin
         for (int k = 0; k < n; k++) begin
            checkOutput("loadWriteAddr", 32'(wrAddrQ[startWr + k]), 32'((base + k) % 512));
            checkOutput("loadWriteData", 32'(wrDataQ[startWr + k]), 32'(stimWords[k]));
         end
      end
      checkOutput("loadDoneOnce", 32'(doneCount - startDone), 32'd1);
      checkOutput("loadChecksum", 32'(o_checksum), 32'(expChecksum(sum)));
   endtask

   // Drives one DUMP, optionally stalling one word and poking start_load mid-transfer, then checks the stream
   task automatic checkOutput_dump(input int base, input int len, input int stallIdx,
                                   input int stallCycles, input bit randomReady, input bit pokeStart);
      int n, cyc, startOut, startDone, startWr, startViol, stallLeft;
      logic [15:0] sum = '0;
      n = (len > 512) ? 512 : len;
      startOut = outQ.size();
      startDone = doneCount;
      startWr = wrAddrQ.size();
      startViol = stableViol;
      stallLeft = stallCycles;
      i_base_addr = 9'(base);
      i_length = 10'(len);
      i_start_dump = 1'b1;
      @(posedge clk); #1;
      i_start_dump = 1'b0;
      cyc = 0;
      while (o_busy && cyc < 20 * n + 50) begin
         if (o_out_valid && (outQ.size() - startOut) == stallIdx && stallLeft > 0) begin
            i_out_ready = 1'b0;
            stallLeft--;
         end else begin
            i_out_ready = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         i_start_load = pokeStart && (cyc == 2);
         @(posedge clk); #1;
         cyc++;
      end
      i_start_load = 1'b0;
      i_out_ready = 1'b0;
      checkOutput("dumpFinished", 32'(o_busy), 32'd0);
      checkOutput("dumpWordCount", 32'(outQ.size() - startOut), 32'(n));
      if (outQ.size() - startOut == n) begin
         for (int k = 0; k < n; k++) begin
            checkOutput("dumpWord", 32'(outQ[startOut + k]), 32'(refMem[(base + k) % 512]));
            sum += refMem[(base + k) % 512];
         end
      end
      checkOutput("dumpDoneOnce", 32'(doneCount - startDone), 32'd1);
      checkOutput("dumpNoWrites", 32'(wrAddrQ.size() - startWr), 32'd0);
      checkOutput("dumpDataStable", 32'(stableViol - startViol), 32'd0);
      checkOutput("dumpChecksum", 32'(o_checksum), 32'(expChecksum(sum)));
   endtask

   initial begin
      int base, len, startDone, ovBefore;
      logic [8:0] addrBefore;
      for (int k = 0; k < 512; k++) begin
         ramMem[k] = '0;
         refMem[k] = '0;
      end
      rst_n = 1'b0;
      i_start_load = 1'b0;
      i_start_dump = 1'b0;
      i_base_addr = '0;
      i_length = '0;
      i_in_valid = 1'b0;
      i_in_data = '0;
      i_out_ready = 1'b0;

      // Reset held two cycles: every output quiet
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstBusy", 32'(o_busy), 32'd0);
      checkOutput("rstDone", 32'(o_done), 32'd0);
      checkOutput("rstInReady", 32'(o_in_ready), 32'd0);
      checkOutput("rstOutValid", 32'(o_out_valid), 32'd0);
      checkOutput("rstOutData", 32'(o_out_data), 32'd0);
      checkOutput("rstChecksum", 32'(o_checksum), 32'd0);
      checkOutput("rstRamAddr", 32'(o_ram_address), 32'd0);
      checkOutput("rstRamDataIn", 32'(o_ram_data_in), 32'd0);
      checkOutput("rstRamWe", 32'(o_ram_write_enable), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] directed load/dump at base 0");
      stimWords = '{16'h1234, 16'hABCD, 16'h0F0F};
      applyStimulus(0, 3, 40, 1'b0);
      checkOutput_dump(0, 3, 1, 4, 1'b0, 1'b1);

      $display("[TB] address wrap 510..1");
      stimWords.delete();
      for (int k = 0; k < 4; k++) stimWords.push_back(16'($urandom));
      applyStimulus(510, 4, 30, 1'b0);
      checkOutput_dump(510, 4, -1, 0, 1'b1, 1'b0);

      $display("[TB] zero-length dump");
      addrBefore = o_ram_address;
      ovBefore = outValidSeen;
      checkOutput_dump(37, 0, -1, 0, 1'b0, 1'b0);
      checkOutput("zeroLenAddrHeld", 32'(o_ram_address), 32'(addrBefore));
      checkOutput("zeroLenNoValid", 32'(outValidSeen - ovBefore), 32'd0);

      $display("[TB] simultaneous starts");
      stimWords = '{16'h5A5A, 16'hC3C3};
      applyStimulus(100, 2, 0, 1'b1);

      $display("[TB] reset during load");
      stimWords = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
      startDone = doneCount;
      i_base_addr = 9'd200;
      i_length = 10'd5;
      i_start_load = 1'b1;
      @(posedge clk); #1;
      i_start_load = 1'b0;
      for (int k = 0; k < 2; k++) begin
         i_in_valid = 1'b1;
         i_in_data = stimWords[k];
         @(posedge clk); #1;
      end
      i_in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midRstBusy", 32'(o_busy), 32'd0);
      checkOutput("midRstInReady", 32'(o_in_ready), 32'd0);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("midRstNoDone", 32'(doneCount - startDone), 32'd0);
      refMem[200] = 16'h1111;
      refMem[201] = 16'h2222;
      checkOutput_dump(200, 3, -1, 0, 1'b1, 1'b0);

      $display("[TB] randomized transfers");
      for (int t = 0; t < 5; t++) begin
         base = int'($urandom_range(0, 511));
         len = int'($urandom_range(1, 24));
         stimWords.delete();
         for (int k = 0; k < len; k++) stimWords.push_back(16'($urandom));
         applyStimulus(base, len, 35, 1'b0);
         checkOutput_dump(base, len, int'($urandom_range(0, 3)), 2, 1'b1, 1'b0);
      end

      $display("[TB] oversize length clamps to full depth");
      stimWords.delete();
      for (int k = 0; k < 512; k++) stimWords.push_back(16'($urandom));
      applyStimulus(300, 700, 10, 1'b0);
      checkOutput_dump(300, 1000, -1, 0, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
